y86_inst_mem: RTL and testbench

- Instruction-memory responder on the far end of the CPU fetch interface.
- Serves one full Y86 instruction window (6 bytes) per PC with a combinational read, so the fetch/decode register captures it on the same edge as the PC.
- Program bytes are written through a byte-stream load port with a valid/ready handshake and a small load state machine.
- Fetches outside a completed program return halt bytes.

---
 rtl/y86_inst_mem.sv | 110 +++++++++++
 tb/tb_y86_inst_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/y86_inst_mem.sv
// ============================================================================
// Module   : y86_inst_mem
// Purpose  : Y86 instruction memory. It returns a 6-byte fetch window for each
//            PC and accepts program bytes through a valid/ready load port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module y86_inst_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   rom_addr_i,
    output logic [47:0]   rom_data_o,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_err,
    output logic [AW:0]   ld_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          done_q, err_q;
    logic          w_accept;

    logic [7:0]    mem [DEPTH];

    // ld_start wins over a byte offered in the same cycle.
    assign w_accept = (state_q == S_LOAD) && ld_valid && !ld_start;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (ld_start) begin
            state_d  = S_LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (w_accept) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            count_d  = count_q + {{AW{1'b0}}, 1'b1};
            if (ld_last) begin
                state_d = S_READY;
            end else if (wr_ptr_q == LAST_PTR) begin
                state_d = S_ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= (state_d == S_READY);
            err_q    <= (state_d == S_ERR);
        end
    end

    // Storage is not reset; count_q and the READY gate hide stale contents.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem[wr_ptr_q] <= ld_data;
        end
    end

    logic [7:0] w_byte [6];

    generate
        for (genvar i = 0; i < 6; i++) begin : g_win
            logic [32:0] w_k;
            logic        w_hit;
            // A 33-bit index keeps PCs near 2^32 from wrapping into low memory.
            assign w_k      = {1'b0, rom_addr_i} + 33'(i);
            assign w_hit    = (state_q == S_READY) && (w_k < 33'(count_q));
            assign w_byte[i] = w_hit ? mem[w_k[AW-1:0]] : 8'h00;
        end
    endgenerate

    assign rom_data_o = {w_byte[0], w_byte[1], w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
    assign ld_ready   = (state_q == S_LOAD);
    assign ld_done    = done_q;
    assign ld_err     = err_q;
    assign ld_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_y86_inst_mem.sv
// ============================================================================
// Module   : tb_y86_inst_mem
// Purpose  : Self-checking bench for y86_inst_mem. It runs with a 16-byte
//            store so that overflow can be reached.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_y86_inst_mem;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   rom_addr_i;
    logic [47:0]   rom_data_o;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic [AW:0]   ld_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] sb_q [$];

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [47:0] exp;
    } fetch_vec_t;

    y86_inst_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .ld_count   (ld_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input string nm, input logic [31:0] pc, input logic [47:0] exp);
        sb_q.push_back(exp);
        rom_addr_i = pc;
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            check(nm, rom_data_o, sb_q.pop_front());
        end
    endtask

    logic [7:0] prog1 [8];
    fetch_vec_t vecs1 [6];

    initial begin
        prog1 = '{8'h30, 8'hf3, 8'h78, 8'h56, 8'h34, 8'h12, 8'h10, 8'h00};
        vecs1[0] = '{"p1_pc0",    32'd0,          48'h30f312345678};
        vecs1[1] = '{"p1_pc6",    32'd6,          48'h100000000000};
        vecs1[2] = '{"p1_pc7",    32'd7,          48'h000000000000};
        vecs1[3] = '{"p1_pc2",    32'd2,          48'h785600101234};
        vecs1[4] = '{"p1_pc_top", 32'hFFFF_FFFE,  48'h000000000000};
        vecs1[5] = '{"p1_pc16",   32'd16,         48'h000000000000};

        rst = 1'b0; rom_addr_i = '0; ld_start = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0;
        repeat (2) tick();

        check("rst_data",  rom_data_o, 48'h0);
        check("rst_ready", 48'(ld_ready), 48'h0);
        check("rst_done",  48'(ld_done), 48'h0);
        check("rst_err",   48'(ld_err), 48'h0);
        check("rst_count", 48'(ld_count), 48'h0);
        rst = 1'b1;
        tick();

        start_load();
        check("ld1_ready", 48'(ld_ready), 48'h1);
        for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
        check("ld1_done",  48'(ld_done), 48'h1);
        check("ld1_rdy0",  48'(ld_ready), 48'h0);
        check("ld1_count", 48'(ld_count), 48'd8);
        for (int i = 0; i < 6; i++) fetch(vecs1[i].name, vecs1[i].pc, vecs1[i].exp);

        // Shorter reload: the old bytes beyond the new count must stay hidden.
        start_load();
        check("ld2_done0", 48'(ld_done), 48'h0);
        send_byte(8'h30, 1'b0);
        send_byte(8'hf3, 1'b0);
        send_byte(8'haa, 1'b1);
        check("ld2_count", 48'(ld_count), 48'd3);
        fetch("p2_pc0", 32'd0, 48'h30f3000000aa);
        fetch("p2_pc1", 32'd1, 48'hf3aa00000000);

        // Overflow without ld_last.
        start_load();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), 1'b0);
        check("ovf_err",   48'(ld_err), 48'h1);
        check("ovf_count", 48'(ld_count), 48'd16);
        check("ovf_ready", 48'(ld_ready), 48'h0);
        check("ovf_done",  48'(ld_done), 48'h0);
        fetch("ovf_pc0", 32'd0, 48'h0);
        start_load();
        check("ovf_clr_err",   48'(ld_err), 48'h0);
        check("ovf_clr_ready", 48'(ld_ready), 48'h1);
        check("ovf_clr_count", 48'(ld_count), 48'h0);

        // ld_start with a same-cycle byte: the byte is dropped.
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hAB; ld_last = 1'b1;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        check("drop_count", 48'(ld_count), 48'h0);
        check("drop_ready", 48'(ld_ready), 48'h1);
        send_byte(8'h60, 1'b1);
        check("one_count", 48'(ld_count), 48'd1);
        fetch("one_pc0", 32'd0, 48'h600000000000);

        // Bytes offered in READY are ignored.
        send_byte(8'hCD, 1'b1);
        send_byte(8'hCE, 1'b0);
        check("rdy_ign_count", 48'(ld_count), 48'd1);
        check("rdy_ign_done",  48'(ld_done), 48'h1);
        fetch("rdy_ign_pc0", 32'd0, 48'h600000000000);

        // Full-depth load ending with ld_last is legal.
        start_load();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), i == DEPTH - 1);
        check("full_done",  48'(ld_done), 48'h1);
        check("full_err",   48'(ld_err), 48'h0);
        check("full_count", 48'(ld_count), 48'd16);
        fetch("full_pc12", 32'd12, 48'h1c1d00001f1e);

        // Asynchronous reset in the middle of a load.
        start_load();
        for (int i = 0; i < 4; i++) send_byte(prog1[i], 1'b0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ready", 48'(ld_ready), 48'h0);
        check("mid_rst_count", 48'(ld_count), 48'h0);
        check("mid_rst_done",  48'(ld_done), 48'h0);
        tick();
        rst = 1'b1;
        tick();
        fetch("mid_rst_pc0", 32'd0, 48'h0);
        check("mid_rst_ready2", 48'(ld_ready), 48'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
